// File: rtl/wb_spi_sram_pkg.sv
// Shared constants, types and lane helpers for the
// Wishbone to SPI SRAM bridge.
package wb_spi_sram_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   typedef struct packed {
      logic [63:0] frame;
      logic [6:0]  nbits;
   } spi_frame_t;

   function automatic logic [1:0] lo_lane(
      input logic [3:0] sel
   );
      lo_lane = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (sel[i]) lo_lane = 2'(i);
   endfunction

   function automatic logic [1:0] hi_lane(
      input logic [3:0] sel
   );
      hi_lane = 2'd0;
      for (int i = 0; i < 4; i++)
         if (sel[i]) hi_lane = 2'(i);
   endfunction

   function automatic logic [31:0] bswap(
      input logic [31:0] d
   );
      bswap = {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/wb_spi_sram_shifter.sv
// SPI bit engine: frame shift register, bit counter,
// sclk phase and miso capture.
module spi_sram_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        active,
   input  logic [63:0] frame,
   input  logic [6:0]  nbits,
   input  logic        miso,
   output logic        mosi,
   output logic        phase,
   output logic        done,
   output logic [31:0] rx_next
);

   logic [63:0] sr;
   logic [6:0]  cnt;
   logic [6:0]  last;
   logic [31:0] rx;

   assign last    = nbits - 7'd1;
   assign mosi    = active & sr[63];
   assign done    = active & phase & (cnt == last);
   assign rx_next = {rx[30:0], miso};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr    <= '0;
         cnt   <= '0;
         phase <= 1'b0;
         rx    <= '0;
      end else if (load) begin
         sr    <= frame;
         cnt   <= '0;
         phase <= 1'b0;
      end else if (active) begin
         if (!phase) begin
            phase <= 1'b1;
         end else begin
            // sample miso at the edge that ends sclk high
            phase <= 1'b0;
            sr    <= {sr[62:0], 1'b0};
            cnt   <= cnt + 7'd1;
            rx    <= rx_next;
         end
      end
   end

endmodule

// File: rtl/wb_spi_sram.sv
// Wishbone slave bridging 32-bit accesses onto a
// serial SPI SRAM (READ 0x03 / WRITE 0x02).
module wb_spi_sram
   import wb_spi_sram_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_spi_cs_n,
   output logic        o_spi_sclk,
   output logic        o_spi_mosi,
   input  logic        i_spi_miso,
   output logic        o_busy
);

   logic [1:0]  state;
   logic        we_q;
   logic        start;
   logic        shifting;
   logic        phase;
   logic        done;
   logic [31:0] rx_next;
   logic [1:0]  lo;
   logic [1:0]  hi;
   logic [2:0]  nbyte;
   logic [23:0] adr_f;
   logic [31:0] data_f;
   spi_frame_t  req;
   logic        unused_adr;

   assign start    = (state == ST_IDLE) & i_wb_cyc;
   assign shifting = (state == ST_SHIFT);

   assign lo = lo_lane(i_wb_sel);
   assign hi = hi_lane(i_wb_sel);

   assign nbyte = (i_wb_sel == 4'd0) ? 3'd0 :
                  3'(hi) - 3'(lo) + 3'd1;

   assign adr_f = 24'({i_wb_adr[ADDR_W-1:2],
                       i_wb_we ? lo : 2'b00});

   // lane lo moves to the top so it leaves first
   assign data_f = bswap(i_wb_dat) << {lo, 3'b000};

   always_comb begin
      req = '0;
      if (i_wb_we) begin
         req.frame = {CMD_WRITE, adr_f, data_f};
         req.nbits = 7'd32 + {1'b0, nbyte, 3'b000};
      end else begin
         req.frame = {CMD_READ, adr_f, 32'h0};
         req.nbits = 7'd64;
      end
   end

   assign unused_adr = &{1'b0, i_wb_adr[31:ADDR_W],
                         i_wb_adr[1:0]};

   spi_sram_shifter u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (start),
      .active  (shifting),
      .frame   (req.frame),
      .nbits   (req.nbits),
      .miso    (i_spi_miso),
      .mosi    (o_spi_mosi),
      .phase   (phase),
      .done    (done),
      .rx_next (rx_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         we_q     <= 1'b0;
         o_wb_rdt <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (i_wb_cyc) begin
                  state <= ST_SHIFT;
                  we_q  <= i_wb_we;
               end
            end
            ST_SHIFT: begin
               if (done) begin
                  state <= ST_ACK;
                  if (!we_q) o_wb_rdt <= bswap(rx_next);
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_spi_cs_n = ~shifting;
   assign o_spi_sclk = shifting & phase;
   assign o_wb_ack   = (state == ST_ACK);
   assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_spi_sram.sv
// Directed bench for wb_spi_sram with a behavioural
// SPI SRAM model on the serial pins.
module tb_wb_spi_sram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0;
   logic [31:0] wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic [31:0] wb_rdt;
   logic        wb_ack;
   logic        cs_n;
   logic        sclk;
   logic        mosi;
   logic        miso = 1'b0;
   logic        busy;

   int n_chk = 0;
   int n_fail = 0;

   wb_spi_sram #(.ADDR_W(24)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wb_adr   (wb_adr),
      .i_wb_dat   (wb_dat),
      .i_wb_sel   (wb_sel),
      .i_wb_we    (wb_we),
      .i_wb_cyc   (wb_cyc),
      .o_wb_rdt   (wb_rdt),
      .o_wb_ack   (wb_ack),
      .o_spi_cs_n (cs_n),
      .o_spi_sclk (sclk),
      .o_spi_mosi (mosi),
      .i_spi_miso (miso),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   // SPI SRAM model
   logic [7:0]  mem [1024];
   logic [63:0] m_fr = '0;
   int          m_len = 0;

   always @(negedge cs_n) begin
      m_fr  = '0;
      m_len = 0;
   end

   always @(posedge sclk) begin
      int a;
      logic [7:0] b;
      if (m_len < 64) m_fr[63-m_len] = mosi;
      if (m_len >= 32 && m_len < 64) begin
         a = int'(m_fr[55:32]);
         b = mem[(a + (m_len - 32) / 8) % 1024];
         miso = b[7 - (m_len % 8)];
      end else begin
         miso = 1'b0;
      end
      m_len++;
   end

   always @(posedge cs_n) begin
      int a;
      if (m_len >= 32 && m_fr[63:56] == 8'h02) begin
         a = int'(m_fr[55:32]);
         for (int j = 0; j < (m_len - 32) / 8; j++)
            mem[(a + j) % 1024] = m_fr[31-8*j -: 8];
      end
   end

   // length of the most recent cs_n-high gap
   int gap_cnt = 0;
   int last_gap = 0;
   always @(posedge clk) begin
      #1;
      if (cs_n) gap_cnt++;
      else if (gap_cnt > 0) begin
         last_gap = gap_cnt;
         gap_cnt = 0;
      end
   end

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
      end
   endtask

   task automatic run_req(input logic [31:0] adr,
                          input logic [31:0] dat,
                          input logic [3:0] sel,
                          input logic we,
                          input int drop_k,
                          input bit hold,
                          output int ack_k);
      ack_k = -1;
      @(posedge clk); #1;
      wb_adr = adr;
      wb_dat = dat;
      wb_sel = sel;
      wb_we  = we;
      wb_cyc = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (k == drop_k) wb_cyc = 1'b0;
         if (k == 1) begin
            chk("busy_t1", busy, 1);
            chk("csn_t1", cs_n, 0);
         end
         if (wb_ack) begin
            ack_k = k;
            chk("ack_csn", cs_n, 1);
            chk("ack_sclk", sclk, 0);
            if (!hold) wb_cyc = 1'b0;
            break;
         end
      end
      if (ack_k < 0) chk("ack_timeout", 0, 1);
   endtask

   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
      int          len;
      logic [63:0] fr;
      int          ack;
      logic [31:0] rdt;
   } vec_t;

   vec_t vt [10];

   task automatic run_vec(input vec_t v, input string tag);
      int ak;
      run_req(v.adr, v.dat, v.sel, v.we, 0, 0, ak);
      chk({tag, "_ack_at"}, 64'(ak), 64'(v.ack));
      chk({tag, "_len"}, 64'(m_len), 64'(v.len));
      chk({tag, "_mosi"}, m_fr, v.fr);
      chk({tag, "_rdt"}, 64'(wb_rdt), 64'(v.rdt));
      @(posedge clk); #1;
      chk({tag, "_ack_1cyc"}, wb_ack, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int ak;
      int ak2;
      bit saw;

      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h104] = 8'h11;
      mem[10'h105] = 8'h22;
      mem[10'h106] = 8'h33;
      mem[10'h107] = 8'h44;

      vt[0] = '{32'h0000_0104, 32'h0, 4'hF, 1'b0, 64,
                64'h03000104_00000000, 129, 32'h44332211};
      vt[1] = '{32'h0000_0200, 32'hDEADBEEF, 4'hF, 1'b1, 64,
                64'h02000200_EFBEADDE, 129, 32'h44332211};
      vt[2] = '{32'h0000_0203, 32'hAB000000, 4'h8, 1'b1, 40,
                64'h02000203_AB000000, 81, 32'h44332211};
      vt[3] = '{32'h0000_0200, 32'h0, 4'hF, 1'b0, 64,
                64'h03000200_00000000, 129, 32'hABADBEEF};
      vt[4] = '{32'h0000_0301, 32'h11223344, 4'h5, 1'b1, 56,
                64'h02000300_44332200, 113, 32'hABADBEEF};
      vt[5] = '{32'h0000_0310, 32'hFFFFFFFF, 4'h0, 1'b1, 32,
                64'h02000310_00000000, 65, 32'hABADBEEF};
      vt[6] = '{32'h0000_0300, 32'h0, 4'hF, 1'b0, 64,
                64'h03000300_00000000, 129, 32'h00223344};
      vt[7] = '{32'hAB00_0106, 32'h0, 4'hF, 1'b0, 64,
                64'h03000104_00000000, 129, 32'h44332211};
      vt[8] = '{32'h0000_03F2, 32'h00CAFE00, 4'h6, 1'b1, 48,
                64'h020003F1_FECA0000, 97, 32'h44332211};
      vt[9] = '{32'h0000_03F0, 32'h0, 4'hF, 1'b0, 64,
                64'h030003F0_00000000, 129, 32'h00CAFE00};

      #3;
      chk("rst_csn", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ack", wb_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdt", 64'(wb_rdt), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_vec(vt[i], $sformatf("v%0d", i));

      chk("mem_202_kept", 64'(mem[10'h202]), 64'hAD);
      chk("mem_303_kept", 64'(mem[10'h303]), 64'h00);

      // cyc dropped early: frame still completes
      run_req(32'h104, 0, 4'hF, 0, 10, 0, ak);
      chk("drop_ack_at", 64'(ak), 129);
      chk("drop_mosi", m_fr, 64'h03000104_00000000);
      chk("drop_rdt", 64'(wb_rdt), 64'h44332211);
      saw = 0;
      repeat (140) begin
         @(posedge clk); #1;
         if (wb_ack) saw = 1;
      end
      chk("drop_one_ack", saw, 0);

      // back-to-back with cyc held high
      run_req(32'h104, 0, 4'hF, 0, 0, 1, ak);
      run_req(32'h200, 0, 4'hF, 0, 0, 0, ak2);
      chk("b2b_ack1_at", 64'(ak), 129);
      chk("b2b_ack2_at", 64'(ak2), 129);
      chk("b2b_gap", 64'(last_gap), 2);
      chk("b2b_rdt", 64'(wb_rdt), 64'hABADBEEF);
      @(posedge clk); #1;

      // reset in the middle of a read
      @(posedge clk); #1;
      wb_adr = 32'h104;
      wb_we  = 1'b0;
      wb_sel = 4'hF;
      wb_cyc = 1'b1;
      saw = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (wb_ack) saw = 1;
      end
      chk("pre_rst_sclk", sclk, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_csn", cs_n, 1);
      chk("arst_sclk", sclk, 0);
      chk("arst_rdt", 64'(wb_rdt), 0);
      chk("arst_busy", busy, 0);
      wb_cyc = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (wb_ack) saw = 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (140) begin
         @(posedge clk); #1;
         if (wb_ack) saw = 1;
      end
      chk("arst_no_ack", saw, 0);
      run_vec(vt[0], "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
